// File: rtl/pp_shift_add_ctrl.sv
// pp_shift_add_ctrl: sequential shift-add multiplier that uses one partial-product row per cycle
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/in_ready, A, B   : operand handshake (unsigned multiplicand / multiplier)
//   out_valid/out_ready, P    : product handshake, P = A*B held until consumed
//   pp_idx, pp_sel  : multiplier bit index and row gate of the current RUN cycle
//   busy            : operation in progress (RUN or DONE)
module pp_shift_add_ctrl #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [WIDTH-1:0]         B,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       P,
  output logic [$clog2(WIDTH)-1:0] pp_idx,
  output logic                     pp_sel,
  output logic                     busy
);
  localparam int IW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] mcand, mplier;
  logic [2*WIDTH-1:0] acc, acc_n;
  logic [IW-1:0] cnt;
  logic last;
  always_comb begin
    acc_n = acc + ({{WIDTH{1'b0}}, mcand & {WIDTH{mplier[0]}}} << cnt);
    // early exit once no set multiplier bits remain beyond the one consumed this cycle
    last = (cnt == IW'(WIDTH - 1)) || (EARLY_EXIT && ((mplier >> 1) == '0));
    state_n = state == IDLE ? (in_valid ? RUN : IDLE) :
              state == RUN  ? (last ? DONE : RUN) :
                              (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      P      <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && in_valid) begin
        mcand  <= A;
        mplier <= B;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state == RUN) begin
        acc    <= acc_n;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (last) P <= acc_n;
      end
    end
  end
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state != IDLE;
  assign pp_sel    = state == RUN && mplier[0];
  assign pp_idx    = cnt;
endmodule

// File: tb/tb_pp_shift_add_ctrl.sv
`timescale 1ns/1ps
// tb_pp_shift_add_ctrl: scoreboard bench for both EARLY_EXIT settings (instance 0: off, 1: on)
module tb_pp_shift_add_ctrl;
  typedef struct {
    logic [31:0] p;
    int          k;
    int          c0;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  logic        iv [2];
  logic [15:0] av [2];
  logic [15:0] bv [2];
  logic        ordy [2];
  logic        irdy [2];
  logic        ovv [2];
  logic [31:0] pv [2];
  logic [3:0]  idx [2];
  logic        sel [2];
  logic        bsy [2];
  logic        hold [2];
  logic        prev [2];
  logic [31:0] held [2];
  logic        rnd;
  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          passes = 0;

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    pp_shift_add_ctrl #(.WIDTH(16), .EARLY_EXIT(g == 1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(irdy[g]), .A(av[g]), .B(bv[g]),
      .out_valid(ovv[g]), .out_ready(ordy[g]), .P(pv[g]), .pp_idx(idx[g]), .pp_sel(sel[g]),
      .busy(bsy[g])
    );
  end

  initial forever begin
    #5 clk = ~clk;
    if (clk) cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int kof(input logic [15:0] b, input int ee);
    int k = 1;
    if (ee == 0) return 16;
    for (int i = 0; i < 16; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b);
    int n = 0;
    exp_t e;
    @(negedge clk);
    av[d] = a;
    bv[d] = b;
    iv[d] = 1'b1;
    while (!irdy[d] && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!irdy[d]) begin
      chk($sformatf("accept_timeout%0d", d), 64'(irdy[d]), 64'd1);
      iv[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    iv[d] = 1'b0;
    av[d] = 16'($urandom);
    bv[d] = 16'($urandom);
    e.p  = 32'(a) * 32'(b);
    e.k  = kof(b, d);
    e.c0 = cyc;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0)
      chk("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (ovv[d] && !prev[d]) begin
          if ((d == 0 ? q0.size() : q1.size()) == 0) begin
            chk($sformatf("unexpected_product%0d", d), 64'(pv[d]), 64'hDEAD);
          end else begin
            if (d == 0) e = q0.pop_front();
            else e = q1.pop_front();
            chk($sformatf("P%0d", d), 64'(pv[d]), 64'(e.p));
            chk($sformatf("latency%0d", d), 64'(cyc - e.c0), 64'(e.k));
            held[d] = e.p;
          end
        end else if (ovv[d]) begin
          chk($sformatf("P_hold%0d", d), 64'(pv[d]), 64'(held[d]));
          chk($sformatf("in_ready_done%0d", d), 64'(irdy[d]), 64'd0);
        end
        prev[d] = ovv[d];
      end
    end
  endtask

  task automatic drive_ready();
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++)
        ordy[d] = hold[d] ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  endtask

  task automatic rnd_ops(input int d);
    logic [15:0] a, b;
    repeat (500) begin
      a = 16'($urandom);
      b = $urandom_range(0, 3) == 0 ? 16'($urandom_range(0, 255)) : 16'($urandom);
      issue(d, a, b);
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    iv = '{1'b1, 1'b1};
    av = '{16'd5, 16'd5};
    bv = '{16'd5, 16'd5};
    ordy = '{1'b1, 1'b1};
    hold = '{1'b0, 1'b0};
    prev = '{1'b0, 1'b0};
    held = '{32'd0, 32'd0};
    rnd = 1'b0;
    fork
      monitor();
      drive_ready();
    join_none
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    iv = '{1'b0, 1'b0};
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_in_ready", 64'(irdy[d]), 64'd1);
      chk("rst_busy", 64'(bsy[d]), 64'd0);
      chk("rst_out_valid", 64'(ovv[d]), 64'd0);
      chk("rst_P", 64'(pv[d]), 64'd0);
      chk("rst_pp_idx", 64'(idx[d]), 64'd0);
      chk("rst_pp_sel", 64'(sel[d]), 64'd0);
    end
    issue(0, 16'hFFFF, 16'hFFFF);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("pp_idx_step", 64'(idx[0]), 64'(i));
      chk("pp_sel_step", 64'(sel[0]), 64'd1);
      chk("busy_run", 64'(bsy[0]), 64'd1);
    end
    drain();
    issue(0, 16'd3, 16'd5);
    drain();
    issue(1, 16'd3, 16'd5);
    drain();
    issue(1, 16'h1234, 16'h0000);
    drain();
    issue(1, 16'h1234, 16'h8000);
    drain();
    issue(1, 16'hFFFF, 16'hFFFF);
    drain();
    hold[0] = 1'b1;
    issue(0, 16'd7, 16'd9);
    n = 0;
    while (!ovv[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 64'(ovv[0]), 64'd1);
    @(negedge clk);
    av[0] = 16'd2;
    bv[0] = 16'd2;
    iv[0] = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("bp_P", 64'(pv[0]), 64'd63);
    chk("bp_busy", 64'(bsy[0]), 64'd1);
    chk("bp_in_ready", 64'(irdy[0]), 64'd0);
    hold[0] = 1'b0;
    issue(0, 16'd2, 16'd2);
    drain();
    issue(0, 16'hFFFF, 16'hFFFF);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q0.delete(q0.size() - 1);
    @(negedge clk);
    chk("abort_out_valid", 64'(ovv[0]), 64'd0);
    chk("abort_P", 64'(pv[0]), 64'd0);
    chk("abort_in_ready", 64'(irdy[0]), 64'd1);
    chk("abort_busy", 64'(bsy[0]), 64'd0);
    issue(0, 16'd100, 16'd200);
    drain();
    rnd = 1'b1;
    fork
      rnd_ops(0);
      rnd_ops(1);
    join
    drain();
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
